// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, synchronous imem address generation, IF/ID register
// and run-control FSM. Define FETCH_PERF_EN to add the stall/flush performance counters.
module fetch_stage #(
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  output logic              state,
  input  logic              op_pc_write,
  input  logic              op_if_id_write,
  input  logic              op_if_id_flush,
  input  logic              op_branch,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              op_halt,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] if_id_ir,
  output logic [ADDR_W-1:0] if_id_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count,
`endif
  output logic              if_id_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fsm_t;

  fsm_t              r_fsm;
  logic              r_state;
  logic              r_exec_d;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_if_pc;
  logic              r_valid;

  logic              w_exec_rise;
  logic              w_run;
  logic              w_frozen;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_exec_rise = exec & ~r_exec_d;
  assign w_run       = (r_fsm == S_RUN);
  assign w_frozen    = ~w_run | op_halt;
  assign w_pc_inc    = r_pc + ADDR_W'(1);

  always_comb begin
    w_pc_next = r_pc;
    if (!w_frozen && op_pc_write) begin
      w_pc_next = op_branch ? branch_target : w_pc_inc;
    end
  end

  // Memory latches pc_next on the same edge as r_pc, so imem_rdata always reflects mem[r_pc].
  assign imem_addr = w_pc_next;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fsm    <= S_IDLE;
      r_state  <= 1'b0;
      r_exec_d <= 1'b0;
    end else begin
      r_exec_d <= exec;
      case (r_fsm)
        S_IDLE: if (w_exec_rise) begin
          r_fsm   <= S_RUN;
          r_state <= 1'b1;
        end
        S_RUN: if (op_halt) begin
          r_fsm   <= S_HALT;
          r_state <= 1'b0;
        end
        S_HALT: if (w_exec_rise) begin
          r_fsm   <= S_RUN;
          r_state <= 1'b1;
        end
        default: begin
          r_fsm   <= S_IDLE;
          r_state <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_if_pc <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (!w_frozen) begin
        if (op_if_id_flush) begin
          r_ir    <= '0;
          r_if_pc <= '0;
          r_valid <= 1'b0;
        end else if (op_if_id_write) begin
          r_ir    <= imem_rdata;
          r_if_pc <= w_pc_inc;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign state       = r_state;
  assign if_id_ir    = r_ir;
  assign if_id_pc    = r_if_pc;
  assign if_id_valid = r_valid;

`ifdef FETCH_PERF_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (w_run) begin
      if (!op_halt && !op_if_id_write && !op_if_id_flush && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (op_if_id_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance at RESET_PC=0 plus a wrap instance at 16'hFFFF.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset, exec;
  logic        op_pc_write, op_if_id_write, op_if_id_flush, op_branch, op_halt;
  logic [15:0] branch_target;
  logic        state, if_id_valid;
  logic [15:0] imem_addr, imem_rdata, if_id_ir, if_id_pc;

  logic        reset2, exec2;
  logic        c_one  = 1'b1;
  logic        c_zero = 1'b0;
  logic [15:0] c_tgt  = 16'h0000;
  logic        state2, if_id_valid2;
  logic [15:0] imem_addr2, imem_rdata2, if_id_ir2, if_id_pc2;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cycles, flush_count, stall_cycles2, flush_count2;
`endif

  logic [15:0] mem [0:63];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock) imem_rdata  <= mem[imem_addr[5:0]];
  always_ff @(posedge clock) imem_rdata2 <= {4'hC, imem_addr2[11:0]};

  fetch_stage #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .exec(exec), .state(state),
    .op_pc_write(op_pc_write), .op_if_id_write(op_if_id_write),
    .op_if_id_flush(op_if_id_flush), .op_branch(op_branch),
    .branch_target(branch_target), .op_halt(op_halt),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_ir(if_id_ir), .if_id_pc(if_id_pc),
`ifdef FETCH_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .if_id_valid(if_id_valid)
  );

  fetch_stage #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clock(clock), .reset(reset2), .exec(exec2), .state(state2),
    .op_pc_write(c_one), .op_if_id_write(c_one),
    .op_if_id_flush(c_zero), .op_branch(c_zero),
    .branch_target(c_tgt), .op_halt(c_zero),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .if_id_ir(if_id_ir2), .if_id_pc(if_id_pc2),
`ifdef FETCH_PERF_EN
    .stall_cycles(stall_cycles2), .flush_count(flush_count2),
`endif
    .if_id_valid(if_id_valid2)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] ir, input logic [15:0] pc,
                            input logic v);
    check_eq({tag, ".ir"}, if_id_ir, ir);
    check_eq({tag, ".pc"}, if_id_pc, pc);
    check_eq({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, v});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 | 16'(i);
    reset = 1'b0; exec = 1'b0; reset2 = 1'b0; exec2 = 1'b0;
    op_pc_write = 1'b0; op_if_id_write = 1'b0; op_if_id_flush = 1'b0;
    op_branch = 1'b0; op_halt = 1'b0; branch_target = 16'h0000;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("rst.state", {15'd0, state}, 16'd0);
    check_ifid("rst", 16'h0000, 16'h0000, 1'b0);
    check_eq("rst.addr", imem_addr, 16'h0000);

    // Start: writes enabled, exec pulse
    op_pc_write = 1'b1; op_if_id_write = 1'b1;
    tick();
    check_eq("idle.addr", imem_addr, 16'h0000);
    exec = 1'b1;
    tick();
    exec = 1'b0;
    check_eq("start.state", {15'd0, state}, 16'd1);
    check_eq("start.valid", {15'd0, if_id_valid}, 16'd0);
    check_eq("start.addr", imem_addr, 16'h0001);
    tick(); check_ifid("f0", 16'hA000, 16'h0001, 1'b1);
    tick(); check_ifid("f1", 16'hA001, 16'h0002, 1'b1);
    tick(); check_ifid("f2", 16'hA002, 16'h0003, 1'b1);
    tick(); check_ifid("f3", 16'hA003, 16'h0004, 1'b1);
    tick(); check_ifid("f4", 16'hA004, 16'h0005, 1'b1);

    // Stall two cycles at pc=5
    op_pc_write = 1'b0; op_if_id_write = 1'b0;
    #1 check_eq("stall.addr0", imem_addr, 16'h0005);
    tick(); check_ifid("stall1", 16'hA004, 16'h0005, 1'b1);
    check_eq("stall.addr1", imem_addr, 16'h0005);
    tick(); check_ifid("stall2", 16'hA004, 16'h0005, 1'b1);
    op_pc_write = 1'b1; op_if_id_write = 1'b1;
    tick(); check_ifid("release", 16'hA005, 16'h0006, 1'b1);
    tick(); check_ifid("f6", 16'hA006, 16'h0007, 1'b1);

    // Branch + flush at pc=7 to 0x20
    op_branch = 1'b1; op_if_id_flush = 1'b1; branch_target = 16'h0020;
    #1 check_eq("br.addr", imem_addr, 16'h0020);
    tick();
    op_branch = 1'b0; op_if_id_flush = 1'b0;
    #1 check_ifid("bubble", 16'h0000, 16'h0000, 1'b0);
    check_eq("br.pc", imem_addr, 16'h0021);
    tick(); check_ifid("tgt", 16'hA020, 16'h0021, 1'b1);

    // Branch (no flush) from 0x21 to 9
    op_branch = 1'b1; branch_target = 16'h0009;
    tick();
    op_branch = 1'b0;
    #1 check_ifid("br9", 16'hA021, 16'h0022, 1'b1);

    // Halt at pc=9
    op_halt = 1'b1;
    #1 check_eq("halt.addr", imem_addr, 16'h0009);
    tick();
    op_halt = 1'b0;
    #1 check_eq("halt.state", {15'd0, state}, 16'd0);
    check_ifid("halt", 16'hA021, 16'h0022, 1'b1);
    tick();
    check_eq("halted.addr", imem_addr, 16'h0009);
    check_ifid("halted", 16'hA021, 16'h0022, 1'b1);
    exec = 1'b1;
    tick(); check_eq("resume.state", {15'd0, state}, 16'd1);
    tick(); check_ifid("r9", 16'hA009, 16'h000A, 1'b1);
    tick(); check_ifid("r10", 16'hA00A, 16'h000B, 1'b1);
    check_eq("exec_high.state", {15'd0, state}, 16'd1);
    exec = 1'b0;

    // Branch without pc_write is ignored
    op_pc_write = 1'b0; op_branch = 1'b1; branch_target = 16'h0030;
    #1 check_eq("nobr.addr", imem_addr, 16'h000B);
    tick();
    check_ifid("nobr", 16'hA00B, 16'h000C, 1'b1);
    check_eq("nobr.addr2", imem_addr, 16'h000B);
    op_branch = 1'b0; op_pc_write = 1'b1;

    // Reset mid-run with everything asserted
    exec = 1'b1; op_if_id_flush = 1'b1; op_branch = 1'b1; reset = 1'b0;
    tick();
    check_eq("mrst.state", {15'd0, state}, 16'd0);
    check_ifid("mrst", 16'h0000, 16'h0000, 1'b0);
    check_eq("mrst.addr", imem_addr, 16'h0000);
    reset = 1'b1; exec = 1'b0; op_if_id_flush = 1'b0; op_branch = 1'b0;
    tick();

`ifdef FETCH_PERF_EN
    check_eq("perf.rst_stall", stall_cycles, 16'd0);
    check_eq("perf.rst_flush", flush_count, 16'd0);
    exec = 1'b1;
    tick();
    exec = 1'b0;
    op_pc_write = 1'b0; op_if_id_write = 1'b0;
    repeat (3) tick();
    op_if_id_flush = 1'b1;
    tick();
    op_if_id_flush = 1'b0; op_pc_write = 1'b1; op_if_id_write = 1'b1;
    tick();
    check_eq("perf.stall3", stall_cycles, 16'd3);
    check_eq("perf.flush1", flush_count, 16'd1);
    op_pc_write = 1'b0; op_if_id_write = 1'b0;
    for (int unsigned i = 0; i < 70000; i++) tick();
    check_eq("perf.sat", stall_cycles, 16'hFFFF);
    tick();
    check_eq("perf.sat_hold", stall_cycles, 16'hFFFF);
    op_pc_write = 1'b1; op_if_id_write = 1'b1;
`endif

    // Wrap instance: RESET_PC = 16'hFFFF
    reset2 = 1'b1;
    tick();
    check_eq("wrap.idle_addr", imem_addr2, 16'hFFFF);
    exec2 = 1'b1;
    tick();
    exec2 = 1'b0;
    check_eq("wrap.state", {15'd0, state2}, 16'd1);
    check_eq("wrap.addr", imem_addr2, 16'h0000);
    tick();
    check_eq("wrap.pc0", if_id_pc2, 16'h0000);
    check_eq("wrap.ir0", if_id_ir2, 16'hCFFF);
    tick();
    check_eq("wrap.pc1", if_id_pc2, 16'h0001);
    check_eq("wrap.ir1", if_id_ir2, 16'hC000);
    reset2 = 1'b0;
    tick();
    check_eq("wrap.rst_state", {15'd0, state2}, 16'd0);
    check_eq("wrap.rst_valid", {15'd0, if_id_valid2}, 16'd0);
    check_eq("wrap.rst_addr", imem_addr2, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage for the pipelined processor: PC register, synchronous instruction-memory address generation, and the IF/ID pipeline register.
- Consumes the write-enable, flush and branch controls that the hazard unit issues.
- Produces the run/stop `state` signal that the hazard unit gates on.
- Owns the run-control FSM that starts on an external exec pulse and stops on halt.

Parameters:
- DATA_W, 16, instruction width.
- ADDR_W, 16, instruction address / PC width.
- RESET_PC, 0, PC value after reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- exec  in  1  run request (level from button; rising edge detected internally)
- state  out  1  1 = RUN, 0 = IDLE or HALT
- op_pc_write  in  1  PC update enable
- op_if_id_write  in  1  IF/ID load enable
- op_if_id_flush  in  1  IF/ID flush (insert bubble)
- op_branch  in  1  branch taken this cycle
- branch_target  in  ADDR_W  PC to load when branch taken
- op_halt  in  1  halt instruction reached a later stage
- imem_addr  out  ADDR_W  address to synchronous instruction memory
- imem_rdata  in  DATA_W  memory data (one-cycle read latency)
- if_id_ir  out  DATA_W  latched instruction
- if_id_pc  out  ADDR_W  PC+1 of latched instruction
- if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Decided: reset is `reset`, synchronous, active-low; clock is `clock`. All state updates occur on the rising edge of `clock`.
- Reset values: FSM=IDLE, pc=RESET_PC, if_id_ir=0 (NOP), if_id_pc=0, if_id_valid=0, exec edge register=0, state=0.
- Run-control FSM, priority as listed:
  - IDLE: on exec rising edge -> RUN.
  - RUN: op_halt=1 -> HALT; otherwise stay in RUN.
  - HALT: on exec rising edge -> RUN, resuming from the held pc.
  - exec edges while in RUN are ignored.
- state output:
  - Registered: state=1 iff FSM==RUN.
  - op_halt takes effect at the clock edge: state drops the cycle after op_halt is seen.
- PC next-value, combinational (pc_next), priority:
  - FSM != RUN, or op_halt=1 -> pc.
  - op_pc_write=1 and op_branch=1 -> branch_target.
  - op_pc_write=1 -> pc+1, wrapping modulo 2^ADDR_W.
  - Otherwise -> pc.
  - pc <= pc_next every cycle.
- Memory interface:
  - imem_addr = pc_next, combinational.
  - Because the memory registers the address on the same edge as pc, imem_rdata in any cycle is mem[pc].
  - No extra fetch latency; a stall holds pc_next=pc so imem_rdata stays valid.
- IF/ID register, priority:
  - FSM != RUN, or op_halt=1 -> hold all fields.
  - op_if_id_flush=1 -> if_id_ir=0, if_id_valid=0, if_id_pc=0. Flush wins over op_if_id_write.
  - op_if_id_write=1 -> if_id_ir=imem_rdata, if_id_pc=pc+1, if_id_valid=1.
  - Otherwise -> hold.
- Branch with flush (both asserted in one cycle):
  - The next cycle holds a bubble in IF/ID and pc=branch_target.
  - The instruction at branch_target enters IF/ID one cycle later.
- Boundary conditions:
  - op_branch=1 with op_pc_write=0 is ignored.
  - pc=2^ADDR_W-1 with write -> pc=0, and if_id_pc=0 for that instruction.
  - Reset mid-RUN returns to IDLE with pc=RESET_PC and IF/ID cleared, regardless of other inputs.
- Latency: first instruction (at RESET_PC) is in IF/ID one cycle after state rises.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds outputs stall_cycles [15:0] and flush_count [15:0]. Both reset to 0 and saturate at 16'hFFFF (no wrap).
  - stall_cycles increments each RUN cycle with op_halt=0, op_if_id_write=0 and op_if_id_flush=0.
  - flush_count increments each RUN cycle with op_if_id_flush=1.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then exec pulse; mem[0..3]=A0,A1,A2,A3 and all writes=1 -> state=1 next cycle; if_id_ir sequence A0,A1,A2,A3 with if_id_pc 1,2,3,4 and if_id_valid=1.
- In RUN, hold op_pc_write=op_if_id_write=0 for 2 cycles at pc=5 -> imem_addr=5, if_id_ir/pc/valid unchanged for 2 cycles; mem[5] loads on release.
- Assert op_branch=op_pc_write=op_if_id_write=op_if_id_flush=1 with branch_target=0x20 at pc=7 -> next cycle if_id_valid=0, if_id_ir=0, pc=0x20; following cycle if_id_ir=mem[0x20], if_id_pc=0x21.
- op_halt=1 at pc=9 -> state=0 next cycle, pc and IF/ID frozen; exec edge -> state=1, fetch resumes at 9; exec held high during RUN causes no effect.
- RESET_PC=16'hFFFF, run 2 cycles -> if_id_pc 0x0000 then 0x0001, imem_addr wraps to 0x0000; assert reset mid-run -> IDLE, pc=0xFFFF, if_id_valid=0.
- With FETCH_PERF_EN: 3 stall cycles plus 1 flush in RUN -> stall_cycles=3, flush_count=1; force 70000 stall cycles -> stall_cycles=0xFFFF held.
